lcd_nibble_reader: RTL and testbench

//  Read-side counterpart of the LCD 4-bit write engine. Performs one HD44780 read cycle
//  (RW=1): strobes lcd_e twice and collects the upper nibble, then the lower nibble, from DB7..DB4.

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_sync2.sv | 23 ++
 rtl/lcd_nibble_reader.sv | 137 +++++++++++++
 tb/tb_lcd_nibble_reader.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: reader state encoding, default bus timing, register-select
// constants and the busy-flag bit position.
package lcd_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TURN,
    S_MSN_EHIGH,
    S_GAP,
    S_LSN_SETUP,
    S_LSN_EHIGH,
    S_RECOVER,
    S_POLL_GAP,
    S_DONE
  } lcd_state_t;

  // Cycle counts common to the read and write engines.
  localparam int T_SETUP_DEF = 2;
  localparam int T_EHIGH_DEF = 12;
  localparam int T_GAP_DEF   = 50;

  localparam logic RS_STATUS = 1'b0;
  localparam logic RS_DATA   = 1'b1;

  localparam int BF_BIT = 7;

  function automatic logic is_ehigh(input lcd_state_t s);
    return (s == S_MSN_EHIGH) || (s == S_LSN_EHIGH);
  endfunction

endpackage

// File: rtl/lcd_sync2.sv
// Two-flop synchronizer for the asynchronous LCD data pins.
module lcd_sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lcd_nibble_reader.sv
// HD44780 4-bit read engine: two E strobes per byte, upper nibble first, with optional
// busy-flag polling bounded by POLL_MAX status reads.
module lcd_nibble_reader
  import lcd_pkg::*;
#(
  parameter int T_SETUP  = T_SETUP_DEF,
  parameter int T_EHIGH  = T_EHIGH_DEF,
  parameter int T_GAP    = T_GAP_DEF,
  parameter int POLL_MAX = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic       poll_busy,
  input  logic [3:0] lcd_db_in,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       timeout,
  output logic       active,
  output lcd_state_t state
);

  localparam int T_MAX0 = (T_SETUP > T_EHIGH) ? T_SETUP : T_EHIGH;
  localparam int T_MAX  = (T_MAX0 > T_GAP) ? T_MAX0 : T_GAP;
  localparam int CW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int PW     = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  logic [CW-1:0] cnt;
  logic [PW-1:0] poll_cnt;
  logic          rs_q;
  logic          poll_q;
  logic [7:0]    byte_q;
  logic [3:0]    db_sync;

  lcd_sync2 #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (lcd_db_in),
    .q     (db_sync)
  );

  function automatic logic last_cycle(input logic [CW-1:0] c, input int t);
    return c == CW'(t - 1);
  endfunction

  // Handshake: start is a one-sided request sampled only in IDLE; active is the busy
  // indication and valid is a single-cycle completion pulse with no back-pressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      poll_cnt <= '0;
      rs_q     <= 1'b0;
      poll_q   <= 1'b0;
      byte_q   <= 8'h00;
      data_out <= 8'h00;
      timeout  <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            state    <= S_TURN;
            rs_q     <= rs;
            poll_q   <= poll_busy;
            timeout  <= 1'b0;
            poll_cnt <= '0;
          end
        end
        S_TURN: if (last_cycle(cnt, T_SETUP)) begin
          state <= S_MSN_EHIGH;
          cnt   <= '0;
        end
        S_MSN_EHIGH: if (last_cycle(cnt, T_EHIGH)) begin
          byte_q[7:4] <= db_sync;
          state       <= S_GAP;
          cnt         <= '0;
        end
        S_GAP: if (last_cycle(cnt, T_GAP)) begin
          state <= S_LSN_SETUP;
          cnt   <= '0;
        end
        S_LSN_SETUP: if (last_cycle(cnt, T_SETUP)) begin
          state <= S_LSN_EHIGH;
          cnt   <= '0;
        end
        S_LSN_EHIGH: if (last_cycle(cnt, T_EHIGH)) begin
          byte_q[3:0] <= db_sync;
          state       <= S_RECOVER;
          cnt         <= '0;
        end
        S_RECOVER: if (last_cycle(cnt, T_SETUP)) begin
          cnt <= '0;
          if (poll_q && (rs_q == RS_STATUS) && byte_q[BF_BIT]) begin
            if (poll_cnt == POLL_LAST) begin
              state    <= S_DONE;
              data_out <= byte_q;
              timeout  <= 1'b1;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
              state    <= S_POLL_GAP;
            end
          end else begin
            state    <= S_DONE;
            data_out <= byte_q;
          end
        end
        S_POLL_GAP: if (last_cycle(cnt, T_GAP)) begin
          state <= S_TURN;
          cnt   <= '0;
        end
        S_DONE: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Bus-facing outputs are pure decodes of the state register, so they cannot glitch.
  assign lcd_e  = is_ehigh(state);
  assign lcd_rw = (state != S_IDLE) && (state != S_DONE);
  assign active = (state != S_IDLE);
  assign lcd_rs = active & rs_q;
  assign valid  = (state == S_DONE);

endmodule

// File: tb/tb_lcd_nibble_reader.sv
// Directed bench for lcd_nibble_reader: table of single reads plus hand sequences for
// strobe timing, poll timeout, held start, glitches and mid-read reset.
module tb_lcd_nibble_reader;
  import lcd_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       start4 = 1'b0;
  logic       rs = 1'b0;
  logic       poll_busy = 1'b0;
  logic [3:0] lcd_db_in;
  logic [3:0] model_db = 4'h0;
  logic [3:0] glitch_db = 4'h0;
  logic [3:0] db4 = 4'h0;
  logic       glitch_en = 1'b0;

  logic       lcd_e, lcd_rs, lcd_rw, valid, timeout, active;
  logic [7:0] data_out;
  lcd_state_t state;
  logic       lcd_e4, lcd_rs4, lcd_rw4, valid4, timeout4, active4;
  logic [7:0] data_out4;
  lcd_state_t state4;

  int n_vec = 0;
  int n_miss = 0;

  // LCD response model state
  logic [7:0] resp_mem[8];
  int         resp_n = 1;
  int         load_gen = 0;
  int         seen_gen = 0;
  int         ridx = 0;
  int         reads = 0;
  logic       half = 1'b0;
  logic [7:0] cur = 8'h00;
  int         reads4 = 0;
  logic       half4 = 1'b0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic       rs;
    logic       poll;
    int         n_busy;
    logic [7:0] busy_byte;
    logic [7:0] final_byte;
    logic [7:0] exp_data;
    logic       exp_to;
    int         exp_lat;
    int         exp_reads;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  assign lcd_db_in = (glitch_en && !lcd_e) ? glitch_db : model_db;

  lcd_nibble_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rs        (rs),
    .poll_busy (poll_busy),
    .lcd_db_in (lcd_db_in),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .data_out  (data_out),
    .valid     (valid),
    .timeout   (timeout),
    .active    (active),
    .state     (state)
  );

  lcd_nibble_reader #(.POLL_MAX(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .start     (start4),
    .rs        (rs),
    .poll_busy (poll_busy),
    .lcd_db_in (db4),
    .lcd_e     (lcd_e4),
    .lcd_rs    (lcd_rs4),
    .lcd_rw    (lcd_rw4),
    .data_out  (data_out4),
    .valid     (valid4),
    .timeout   (timeout4),
    .active    (active4),
    .state     (state4)
  );

  // Main LCD model: presents the next queued byte, upper nibble on the first strobe.
  always @(posedge lcd_e or posedge reset) begin
    if (reset) begin
      half = 1'b0;
    end else if (!half) begin
      if (seen_gen != load_gen) begin
        seen_gen = load_gen;
        ridx = 0;
      end
      cur = (ridx < resp_n) ? resp_mem[ridx] : resp_mem[resp_n-1];
      ridx++;
      model_db = cur[7:4];
      half = 1'b1;
    end else begin
      model_db = cur[3:0];
      half = 1'b0;
      reads++;
    end
  end

  // Stuck-busy model for the POLL_MAX=4 instance: always returns 8'h9F.
  always @(posedge lcd_e4 or posedge reset) begin
    if (reset) begin
      half4 = 1'b0;
    end else if (!half4) begin
      db4 = 4'h9;
      half4 = 1'b1;
    end else begin
      db4 = 4'hF;
      half4 = 1'b0;
      reads4++;
    end
  end

  always @(negedge clk) glitch_db = 4'($urandom_range(0, 15));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic load1(input logic [7:0] b);
    resp_mem[0] = b;
    resp_n = 1;
    load_gen++;
  endtask

  // Pulses start, then waits (bounded) for valid counting cycles from the accepting edge.
  task automatic do_read(input logic r, input logic p, input logic [7:0] exp_d,
                         input logic exp_to, input int exp_lat, input int exp_reads,
                         input string tag);
    int k;
    int r0;
    bit got;
    r0 = reads;
    @(negedge clk);
    rs = r;
    poll_busy = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    got = 0;
    while (!got && k < 3000) begin
      if (k == 40) check({tag, "_lcd_rs"}, 32'(lcd_rs), 32'(r));
      if (valid) got = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_data"}, 32'(data_out), 32'(exp_d));
    check({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
    check({tag, "_reads"}, reads - r0, exp_reads);
    @(negedge clk);
    check({tag, "_valid_pulse"}, 32'(valid), 32'd0);
  endtask

  initial begin
    int e_bad, rw_bad, e_hi, valid_k, k, n_v;
    int vk[$];

    vecs[0] = '{1'b1, 1'b0, 0, 8'h00, 8'hA5, 8'hA5, 1'b0, 80, 1};
    vecs[1] = '{1'b0, 1'b1, 3, 8'h8A, 8'h23, 8'h23, 1'b0, 470, 4};
    vecs[2] = '{1'b0, 1'b0, 0, 8'h00, 8'hC1, 8'hC1, 1'b0, 80, 1};
    vecs[3] = '{1'b1, 1'b1, 0, 8'h00, 8'hFF, 8'hFF, 1'b0, 80, 1};
    vecs[4] = '{1'b0, 1'b1, 1, 8'hB0, 8'h7F, 8'h7F, 1'b0, 210, 2};
    vecs[5] = '{1'b0, 1'b0, 0, 8'h00, 8'h80, 8'h80, 1'b0, 80, 1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_lcd_e", 32'(lcd_e), 0);
    check("rst_lcd_rs", 32'(lcd_rs), 0);
    check("rst_lcd_rw", 32'(lcd_rw), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_active", 32'(active), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_state", 32'(state), 32'(S_IDLE));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Strobe timing of a single data read
    load1(8'hA5);
    @(negedge clk);
    rs = 1'b1;
    poll_busy = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e_bad = 0; rw_bad = 0; e_hi = 0; valid_k = -1;
    for (int i = 0; i <= 80; i++) begin
      if (lcd_e !== (((i >= 2) && (i <= 13)) || ((i >= 66) && (i <= 77)))) e_bad++;
      if (lcd_e === 1'b1) e_hi++;
      if (lcd_rw !== (i < 80)) rw_bad++;
      if (valid === 1'b1 && valid_k < 0) valid_k = i;
      if (i == 30) check("t1_lcd_rs", 32'(lcd_rs), 1);
      if (i < 80) @(negedge clk);
    end
    check("t1_e_pattern_errs", e_bad, 0);
    check("t1_e_high_cycles", e_hi, 24);
    check("t1_rw_pattern_errs", rw_bad, 0);
    check("t1_valid_cycle", valid_k, 80);
    check("t1_data", 32'(data_out), 32'hA5);
    @(negedge clk);
    check("t1_idle_rw", 32'(lcd_rw), 0);

    // Table of single reads
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < vecs[i].n_busy; j++) resp_mem[j] = vecs[i].busy_byte;
      resp_mem[vecs[i].n_busy] = vecs[i].final_byte;
      resp_n = vecs[i].n_busy + 1;
      load_gen++;
      do_read(vecs[i].rs, vecs[i].poll, vecs[i].exp_data, vecs[i].exp_to,
              vecs[i].exp_lat, vecs[i].exp_reads, $sformatf("v%0d", i));
    end

    // Poll limit with busy stuck on the POLL_MAX=4 instance
    @(negedge clk);
    rs = 1'b0;
    poll_busy = 1'b1;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    k = 0;
    while (!valid4 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("t3_latency", k, 470);
    check("t3_data", 32'(data_out4), 32'h9F);
    check("t3_timeout", 32'(timeout4), 1);
    check("t3_reads", reads4, 4);

    // Start held high for 300 cycles with glitches on the pins while E is low
    resp_mem[0] = 8'h11; resp_mem[1] = 8'h22; resp_mem[2] = 8'h33; resp_mem[3] = 8'h44;
    resp_n = 4;
    load_gen++;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    glitch_en = 1'b1;
    @(negedge clk);
    rs = 1'b1;
    poll_busy = 1'b0;
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      if (valid) begin
        vk.push_back(i);
        if (exp_q.size() > 0) check($sformatf("t6_data_at_%0d", i), 32'(data_out), 32'(exp_q.pop_front()));
        else check($sformatf("t6_extra_valid_at_%0d", i), 1, 0);
      end
      if (i < 299) @(negedge clk);
    end
    start = 1'b0;
    check("t6_valid_count", vk.size(), 3);
    if (vk.size() == 3) begin
      check("t6_valid0", vk[0], 80);
      check("t6_valid1", vk[1], 162);
      check("t6_valid2", vk[2], 244);
    end
    k = 0;
    while (active && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t6_drain_idle", 32'(active), 0);
    check("t6_drain_data", 32'(data_out), 32'h44);

    // Extra start pulses mid-read are ignored, and rs stays latched
    load1(8'h5A);
    @(negedge clk);
    rs = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_v = 0;
    valid_k = -1;
    for (int i = 0; i < 200; i++) begin
      if (i == 20 || i == 50 || i == 70) begin
        start = 1'b1;
        rs = 1'b0;
      end else start = 1'b0;
      if (i == 71) check("t6b_lcd_rs_latched", 32'(lcd_rs), 1);
      if (valid) begin
        n_v++;
        valid_k = i;
      end
      @(negedge clk);
    end
    check("t6b_valid_count", n_v, 1);
    check("t6b_valid_cycle", valid_k, 80);
    check("t6b_data", 32'(data_out), 32'h5A);
    glitch_en = 1'b0;

    // Reset in the 5th cycle of MSN_EHIGH
    load1(8'h77);
    @(negedge clk);
    rs = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_pre_e", 32'(lcd_e), 1);
    reset = 1'b1;
    #1;
    check("t5_e_drop", 32'(lcd_e), 0);
    check("t5_rw_drop", 32'(lcd_rw), 0);
    check("t5_active_drop", 32'(active), 0);
    check("t5_data_clear", 32'(data_out), 0);
    @(negedge clk);
    reset = 1'b0;
    n_v = 0;
    for (int i = 0; i < 120; i++) begin
      if (valid) n_v++;
      @(negedge clk);
    end
    check("t5_no_valid", n_v, 0);
    load1(8'h3C);
    do_read(1'b1, 1'b0, 8'h3C, 1'b0, 80, 1, "t5_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
